// File: rtl/clock_ctrl.sv
// ---------------------------------------------------------------------------
// ClockCtrl: control block for an HH:MM digital clock.
//
// Generates the one-second enable for the time datapath and runs the
// RUN -> SET_HR -> SET_MIN edit cycle driven by two push buttons.
// In the set states the displayed digits are captured into a binary shadow
// register. The shadow is incremented by the inc button and presented to
// the datapath as a load value.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-low reset
//   btn_mode  in   mode button (asynchronous, active-high level)
//   btn_inc   in   increment button (asynchronous, active-high level)
//   hh_t/hh_u in   current BCD hour digits (tens/units)
//   mm_t/mm_u in   current BCD minute digits (tens/units)
//   en_sec    out  one-cycle seconds-count enable
//   sel_hr    out  1 = hour counter counts carries, 0 = loads set_hr
//   sel_min   out  1 = minute counter counts carries, 0 = loads set_min
//   set_hr    out  binary hour load value
//   set_min   out  binary minute load value
//   mode      out  00 RUN, 01 SET_HR, 10 SET_MIN
// ---------------------------------------------------------------------------
module clock_ctrl #(
  parameter int unsigned DIV     = 1000,
  parameter int unsigned TIMEOUT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] hh_t,
  input  logic [3:0] hh_u,
  input  logic [3:0] mm_t,
  input  logic [3:0] mm_u,
  output logic       en_sec,
  output logic       sel_hr,
  output logic       sel_min,
  output logic [7:0] set_hr,
  output logic [7:0] set_min,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_e;

  localparam logic [23:0] PRESC_LAST = 24'(DIV - 1);
  localparam logic [7:0]  IDLE_LAST  = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic [7:0]  idle_q, idle_d;
  logic [7:0]  hrShadow_q, hrShadow_d;
  logic [7:0]  minShadow_q, minShadow_d;
  logic        enSec_q, enSec_d;
  logic        selHr_q, selHr_d;
  logic        selMin_q, selMin_d;

  logic [1:0]  modeSync_q, incSync_q;
  logic        modePrev_q, incPrev_q;
  logic [1:0]  armCnt_q;

  logic        armed, modePress, incPress, tick, enterRun;
  logic [7:0]  hrRaw, minRaw, hrCap, minCap;

  // Button synchronizers. armCnt_q holds off edge detection until the
  // previous-value flop carries a genuinely sampled level, so a button held
  // through reset release never looks like a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      modeSync_q <= '0;
      incSync_q  <= '0;
      modePrev_q <= 1'b0;
      incPrev_q  <= 1'b0;
      armCnt_q   <= '0;
    end else begin
      modeSync_q <= {modeSync_q[0], btn_mode};
      incSync_q  <= {incSync_q[0], btn_inc};
      modePrev_q <= modeSync_q[1];
      incPrev_q  <= incSync_q[1];
      if (armCnt_q != 2'd3) armCnt_q <= armCnt_q + 2'd1;
    end
  end

  assign armed     = (armCnt_q == 2'd3);
  assign modePress = armed & modeSync_q[1] & ~modePrev_q;
  assign incPress  = armed & incSync_q[1] & ~incPrev_q;
  assign tick      = (presc_q == PRESC_LAST);

  // BCD digits to binary; anything that is not a legal time of day loads 0.
  always_comb begin
    hrRaw  = 8'(hh_t) * 8'd10 + 8'(hh_u);
    minRaw = 8'(mm_t) * 8'd10 + 8'(mm_u);
    hrCap  = (hh_t > 4'd9 || hh_u > 4'd9 || hrRaw > 8'd23) ? 8'd0 : hrRaw;
    minCap = (mm_t > 4'd9 || mm_u > 4'd9 || minRaw > 8'd59) ? 8'd0 : minRaw;
  end

  // Next-state logic. The prescaler always runs; in the set states its wrap
  // is the idle-second tick. A press in a set state takes priority over a
  // tick, which is what lets a mode press beat a simultaneous timeout.
  always_comb begin
    state_d     = state_q;
    presc_d     = tick ? 24'd0 : presc_q + 24'd1;
    idle_d      = idle_q;
    hrShadow_d  = hrShadow_q;
    minShadow_d = minShadow_q;
    enterRun    = 1'b0;

    case (state_q)
      RUN: begin
        idle_d = '0;
        if (modePress) begin
          state_d    = SET_HR;
          hrShadow_d = hrCap;
        end
      end
      SET_HR: begin
        if (modePress) begin
          state_d     = SET_MIN;
          minShadow_d = minCap;
          idle_d      = '0;
        end else if (incPress) begin
          hrShadow_d = (hrShadow_q >= 8'd23) ? 8'd0 : hrShadow_q + 8'd1;
          idle_d     = '0;
        end else if (tick) begin
          if (idle_q == IDLE_LAST) enterRun = 1'b1;
          else                     idle_d   = idle_q + 8'd1;
        end
      end
      SET_MIN: begin
        if (modePress) begin
          enterRun = 1'b1;
        end else if (incPress) begin
          minShadow_d = (minShadow_q >= 8'd59) ? 8'd0 : minShadow_q + 8'd1;
          idle_d      = '0;
        end else if (tick) begin
          if (idle_q == IDLE_LAST) enterRun = 1'b1;
          else                     idle_d   = idle_q + 8'd1;
        end
      end
      default: enterRun = 1'b1;
    endcase

    // Every way back into RUN restarts the second so the first en_sec
    // arrives a full DIV cycles later.
    if (enterRun) begin
      state_d = RUN;
      presc_d = '0;
      idle_d  = '0;
    end

    enSec_d  = (state_q == RUN) && (state_d == RUN) && tick;
    selHr_d  = (state_d != SET_HR);
    selMin_d = (state_d != SET_MIN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      presc_q     <= '0;
      idle_q      <= '0;
      hrShadow_q  <= '0;
      minShadow_q <= '0;
      enSec_q     <= 1'b0;
      selHr_q     <= 1'b1;
      selMin_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      idle_q      <= idle_d;
      hrShadow_q  <= hrShadow_d;
      minShadow_q <= minShadow_d;
      enSec_q     <= enSec_d;
      selHr_q     <= selHr_d;
      selMin_q    <= selMin_d;
    end
  end

  assign en_sec  = enSec_q;
  assign sel_hr  = selHr_q;
  assign sel_min = selMin_q;
  assign set_hr  = hrShadow_q;
  assign set_min = minShadow_q;
  assign mode    = state_q;

endmodule
